// File: rtl/alu_fu_pkg.sv
// rtl/alu_fu_pkg.sv - ALU functional-unit operand bundle shared by the ALU and its feeders
package alu_fu_pkg;

    localparam int XLEN   = 32;
    localparam int PREG_W = 6;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef struct packed {
        alu_op_t           op;
        logic [PREG_W-1:0] prd;
        logic [XLEN-1:0]   rs1val;
        logic [XLEN-1:0]   rs2val;
    } fu_input_t;

endpackage

// File: rtl/alu_issue_queue_pkg.sv
// rtl/alu_issue_queue_pkg.sv - queue entry, wakeup bus types and sizing defaults for alu_issue_queue
package alu_issue_queue_pkg;

    import alu_fu_pkg::*;

    localparam int ALU_IQ_DEPTH    = 8;
    localparam int ALU_IQ_WB_PORTS = 2;

    // Dispatched micro-op: the ALU payload plus source tags and their ready bits.
    typedef struct packed {
        fu_input_t         fu;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic              rs1_rdy;
        logic              rs2_rdy;
    } iq_entry_t;

    // One writeback broadcast: physical destination tag and its result value.
    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] prd;
        logic [XLEN-1:0]   value;
    } wakeup_t;

endpackage

// File: rtl/alu_iq_select.sv
// rtl/alu_iq_select.sv - oldest-ready picker for the ALU issue queue
//   ready_i : per-slot ready vector, bit 0 is the oldest slot
//   grant_o : one-hot grant of the lowest-index ready slot (all zero if none)
//   found_o : at least one slot is ready
module alu_iq_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0] ready_i,
    output logic [DEPTH-1:0] grant_o,
    output logic             found_o
);

    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_i[i] && !found_o) begin
                grant_o[i] = 1'b1;
                found_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - out-of-order collapsing issue queue feeding the integer ALU
//   clk, rstn           : clock, asynchronous active-low reset
//   flush_i             : squash all queued entries and the issue register
//   disp_valid_i/_ready_o, disp_entry_i : dispatch handshake and micro-op
//   wb_i                : WB_PORTS writeback broadcasts used for operand wakeup
//   issue_valid_o/issue_ready_i, issue_o : registered micro-op to the ALU
// Optional feature macro: ALU_IQ_BYPASS_EN (empty-queue dispatch straight into the issue register)
module alu_issue_queue
    import alu_fu_pkg::*;
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH    = ALU_IQ_DEPTH,
    parameter int WB_PORTS = ALU_IQ_WB_PORTS
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush_i,
    input  logic                     disp_valid_i,
    output logic                     disp_ready_o,
    input  iq_entry_t                disp_entry_i,
    input  wakeup_t [WB_PORTS-1:0]   wb_i,
    output logic                     issue_valid_o,
    input  logic                     issue_ready_i,
    output fu_input_t                issue_o
);

    localparam int CW = $clog2(DEPTH + 1);

    iq_entry_t        slots_q [DEPTH];
    iq_entry_t        slots_d [DEPTH];
    iq_entry_t        slot_wk [DEPTH];
    iq_entry_t        disp_wk;
    logic [CW-1:0]    count_q, count_d;
    logic             issue_valid_q, issue_valid_d;
    fu_input_t        issue_q, issue_d;

    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] grant;
    logic             found;
    logic             select_en;
    logic             sel_fire;
    logic             disp_fire;
    logic             disp_write;
    logic             bypass;
    logic [CW-1:0]    wr_idx;
    fu_input_t        sel_fu;
    logic             shift_run;

    // Operand capture from the writeback buses. Ports are scanned from the
    // highest index down so the lowest-index match is the one that sticks.
    function automatic iq_entry_t capture(input iq_entry_t e, input wakeup_t [WB_PORTS-1:0] wb);
        iq_entry_t r;
        r = e;
        for (int k = WB_PORTS - 1; k >= 0; k--) begin
            if (wb[k].valid && !e.rs1_rdy && (wb[k].prd == e.prs1)) begin
                r.fu.rs1val = wb[k].value;
                r.rs1_rdy   = 1'b1;
            end
            if (wb[k].valid && !e.rs2_rdy && (wb[k].prd == e.prs2)) begin
                r.fu.rs2val = wb[k].value;
                r.rs2_rdy   = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_wk[i] = capture(slots_q[i], wb_i);
        end
        disp_wk = capture(disp_entry_i, wb_i);
    end

    // Readiness looks only at registered ready bits, so a wakeup this cycle
    // becomes selectable next cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = (CW'(i) < count_q) && slots_q[i].rs1_rdy && slots_q[i].rs2_rdy;
        end
    end

    alu_iq_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .ready_i (ready_vec),
        .grant_o (grant),
        .found_o (found)
    );

    assign disp_ready_o = (count_q < CW'(DEPTH));
    assign select_en    = !issue_valid_q || issue_ready_i;
    assign sel_fire     = select_en && found;
    assign disp_fire    = disp_valid_i && disp_ready_o;

`ifdef ALU_IQ_BYPASS_EN
    // Empty queue means nothing older can be waiting, so a fully ready
    // dispatch may go straight to the ALU without breaking age order.
    assign bypass = disp_fire && (count_q == '0) && select_en
                    && disp_wk.rs1_rdy && disp_wk.rs2_rdy;
`else
    assign bypass = 1'b0;
`endif

    assign disp_write = disp_fire && !bypass && !flush_i;
    // The selected slot leaves in the same edge, so the tail moves down by one.
    assign wr_idx     = count_q - CW'(sel_fire);

    always_comb begin
        sel_fu = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_fu = slots_q[i].fu;
            end
        end
    end

    // Collapse: every slot at or above the granted one takes its younger
    // neighbour; the dispatched entry then lands at the new tail.
    always_comb begin
        shift_run = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slots_d[i] = slot_wk[i];
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift_run = shift_run | (sel_fire & grant[i]);
            if (shift_run) begin
                slots_d[i] = slot_wk[i + 1];
            end
        end
        if (shift_run | (sel_fire & grant[DEPTH-1])) begin
            slots_d[DEPTH-1] = '0;
        end
        if (disp_write) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    slots_d[i] = disp_wk;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q - CW'(sel_fire) + CW'(disp_write);
        if (flush_i) begin
            count_d = '0;
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_d       = issue_q;
        if (flush_i) begin
            issue_valid_d = 1'b0;
        end else if (select_en) begin
            if (sel_fire) begin
                issue_d       = sel_fu;
                issue_valid_d = 1'b1;
            end else if (bypass) begin
                issue_d       = disp_wk.fu;
                issue_valid_d = 1'b1;
            end else begin
                issue_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q       <= '0;
            issue_valid_q <= 1'b0;
            issue_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            count_q       <= count_d;
            issue_valid_q <= issue_valid_d;
            issue_q       <= issue_d;
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

    assign issue_valid_o = issue_valid_q;
    assign issue_o       = issue_q;

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Out-of-order issue queue sitting directly upstream of the integer ALU functional unit. Accepts dispatched ALU micro-ops whose source operands may still be pending. Captures operand values from the writeback broadcast buses, selects the oldest fully-ready entry each cycle, and drives a registered `fu_input_t` into the ALU.

## Interface
- `DEPTH`, 8: number of queue entries, ≥2.
- `WB_PORTS`, 2: number of writeback broadcast buses snooped for wakeup.
- `clk`  in  1  clock.
- `rstn`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  squash all entries and the issue register.
- `disp_valid_i`  in  1  dispatch request.
- `disp_ready_o`  out  1  queue can accept; high when `count < DEPTH`.
- `disp_entry_i`  in  `iq_entry_t`  `fu_input_t` payload plus `prs1`, `prs2`, `rs1_rdy`, `rs2_rdy`.
- `wb_i`  in  `wakeup_t [WB_PORTS]`  each entry is {`valid`, `prd`, `value`}.
- `issue_valid_o`  out  1  `issue_o` holds a valid micro-op.
- `issue_ready_i`  in  1  ALU accepts (ALU is single-cycle; normally 1).
- `issue_o`  out  `fu_input_t`  registered micro-op for the ALU.

## Operation
- Storage is a collapsing queue, slot 0 oldest. `count` is in 0..DEPTH. Slot i is valid iff i < count.
- **Dispatch**: a transfer occurs when `disp_valid_i && disp_ready_o`. The entry is written at slot `count − (issued this cycle ? 1 : 0)`.
- **Dispatch readiness**: `disp_ready_o` ignores same-cycle issue, so a full queue never accepts.
- **Operand capture**:
  - An entry whose `rsN_rdy` is 0 compares `prsN` against every valid `wb_i[k].prd`.
  - On a match, `value` is written into `rsNval` and `rsN_rdy` is set.
  - The lowest-index port wins on multiple matches.
  - The same comparison applies to the entry being dispatched in this cycle. A wakeup coincident with dispatch is never lost.
- **Ready**: an entry is ready when `rs1_rdy && rs2_rdy`. Readiness is evaluated on registered state only, so a wakeup in cycle t makes the entry selectable at t+1.
- **Select**:
  - Select happens when the issue register is empty or is being drained (`!issue_valid_o || issue_ready_i`).
  - The lowest-index ready entry is chosen and loaded into the issue register.
  - Younger slots shift down one position in the same edge.
- **Issue stall**: while `issue_valid_o && !issue_ready_i`:
  - `issue_o` holds stable.
  - No select occurs.
  - Wakeup and dispatch continue.
- **Flush**: clears `count` and `issue_valid_o` at the next edge. It overrides dispatch, select and wakeup in the same cycle. `disp_ready_o` stays high during flush.
- **Reset**: `count` = 0, `issue_valid_o` = 0, `issue_o` = '0, all slot valid/ready bits = 0. `disp_ready_o` reads 1 after reset.
- **Order**: among ready entries, program order is preserved. Ready younger entries may bypass non-ready older entries.

## Timing
- Dispatch of a ready entry in cycle t: it occupies its slot at t+1, is selected in t+1, and `issue_valid_o` is asserted at t+2.
- Wakeup in cycle t of a waiting entry: it is selectable at t+1 and appears on `issue_o` at t+2.
- Throughput: one issue per cycle with `issue_ready_i` = 1.
- `count` next value = count + disp − issue, or 0 on flush. Underflow and overflow are impossible by construction.

## Configuration
- `ALU_IQ_BYPASS_EN` defined:
  - Applies when the queue is empty (count == 0), the issue register is free or draining, and the dispatched entry is fully ready after same-cycle wakeup capture.
  - The entry loads directly into the issue register and is not written to the queue.
  - Issue latency drops to t+1.
- `ALU_IQ_BYPASS_EN` undefined: every dispatch goes through a slot (t+2 minimum).

## Structure
- Shared package: `iq_entry_t`, `wakeup_t`, and the defaults for `ALU_IQ_DEPTH` and `WB_PORTS`. `fu_input_t` stays where it already lives.
- Sub-module `alu_iq_select`: combinational oldest-ready picker. It takes the DEPTH-bit ready vector and returns a one-hot grant plus a found flag.
- Shift and compaction logic stays in the top module.

## Test plan
- **Basic issue**: reset, then dispatch ADD (rs1_rdy = rs2_rdy = 1, rs1val = 5, rs2val = 7) → `issue_valid_o` = 1 at t+2 with `issue_o.rs1val` = 5; `count` returns to 0. With `ALU_IQ_BYPASS_EN`, issue occurs at t+1.
- **Wakeup**:
  - Dispatch entry A with `prs1` = 12 not ready, then B fully ready → B issues first.
  - Broadcast `wb_i[1]` = {1, 12, 0xDEAD} → A issues two cycles later with `rs1val` = 0xDEAD.
- **Same-cycle wakeup and dispatch**: dispatch `prs2` = 3 not ready while `wb_i[0]` = {1, 3, 42} → entry is stored with `rs2val` = 42 and ready.
- **Full**:
  - Fill 8 non-ready entries → `disp_ready_o` = 0.
  - A held dispatch is not accepted even when one entry wakes and issues that cycle.
  - The dispatch is accepted the following cycle.
- **Stall**: hold `issue_ready_i` = 0 for 3 cycles with two ready entries → `issue_o` is stable. On release, the entries issue in age order on consecutive cycles.
- **Flush / reset mid-operation**:
  - Flush with 5 entries and a valid issue register, plus a coincident dispatch → `count` = 0, `issue_valid_o` = 0, and the dispatch is dropped.
  - Asynchronous `rstn` low mid-cycle → outputs clear immediately.
